// File: rtl/ps2_device_port_if.sv
// Byte-level user side of the PS/2 device port: TX byte offer and RX byte/error results.
// Latency: none, plain wires between the user logic and the port.
// Backpressure: tx_valid/tx_ready handshake on TX; RX results are unthrottled one-cycle pulses.
interface ps2_device_port_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_err, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_err, busy
    );
endinterface

// File: rtl/ps2_device_port.sv
// PS/2 device-side port: clocks buffered bytes out to the host and clocks host command bytes in.
// Latency: pads seen through 2-flop syncs; TX starts once both lines idle IDLE cycles.
// Backpressure: single-byte buffer, tx_ready low from acceptance until the byte is fully sent.
module ps2_device_port #(
    parameter int CLKFREQ = 12_000_000,
    parameter int HALF_US = 40,
    parameter int IDLE_US = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2clk_in,
    input  logic ps2dta_in,
    output logic ps2clk_oe,
    output logic ps2dta_oe,
    ps2_device_port_if.slave bus
);
    localparam int CPU = CLKFREQ / 1_000_000;
    localparam logic [15:0] HALF_C = 16'(CPU * HALF_US);
    localparam logic [15:0] IDLE_C = 16'(CPU * IDLE_US);
    localparam logic [15:0] CHK_C  = 16'(CPU * 5);          // inhibit check starts 5 us into a high phase
    localparam logic [15:0] MID_C  = 16'(CPU * HALF_US / 2); // sample point inside a high phase

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_HOLD} state_t;

    state_t      state, state_n;
    logic        clk_m, clk_s, dta_m, dta_s;
    logic [15:0] idle_cnt, rts_cnt;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  bitn, bitn_n;
    logic        ph, ph_n;               // 0 = first phase of a bit/pulse, 1 = second
    logic        clk_oe_q, clk_oe_n, dta_oe_q, dta_oe_n;
    logic [7:0]  rx_sh, rx_sh_n, rx_data_q, rx_data_n;
    logic        rx_par, rx_par_n;
    logic        rx_valid_q, rx_valid_n, rx_err_q, rx_err_n;
    logic        buf_full, buf_full_n;
    logic [7:0]  buf_dat, buf_dat_n;
    logic        up;                     // low only in reset, gates tx_ready
    logic        phase_end;
    logic [10:0] tx_frame;

    assign tx_frame  = {1'b1, ~^buf_dat, buf_dat, 1'b0};
    assign phase_end = (cnt == HALF_C - 16'd1);

    assign ps2clk_oe    = clk_oe_q;
    assign ps2dta_oe    = dta_oe_q;
    assign bus.tx_ready = up & ~buf_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.busy     = (state != S_IDLE) | buf_full;

    // Pad synchronizers plus the idle and request-to-send qualification counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_m    <= 1'b1;
            clk_s    <= 1'b1;
            dta_m    <= 1'b1;
            dta_s    <= 1'b1;
            idle_cnt <= '0;
            rts_cnt  <= '0;
            up       <= 1'b0;
        end else begin
            clk_m <= ps2clk_in;
            clk_s <= clk_m;
            dta_m <= ps2dta_in;
            dta_s <= dta_m;
            up    <= 1'b1;
            if (clk_s && dta_s) begin
                if (idle_cnt != IDLE_C) idle_cnt <= idle_cnt + 16'd1;
            end else begin
                idle_cnt <= '0;
            end
            if (clk_s && !dta_s) begin
                if (rts_cnt != HALF_C) rts_cnt <= rts_cnt + 16'd1;
            end else begin
                rts_cnt <= '0;
            end
        end
    end

    // State, bit timing, registered line enables, RX result and TX buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            ph         <= 1'b0;
            clk_oe_q   <= 1'b0;
            dta_oe_q   <= 1'b0;
            rx_sh      <= '0;
            rx_par     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            buf_full   <= 1'b0;
            buf_dat    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bitn       <= bitn_n;
            ph         <= ph_n;
            clk_oe_q   <= clk_oe_n;
            dta_oe_q   <= dta_oe_n;
            rx_sh      <= rx_sh_n;
            rx_par     <= rx_par_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            rx_err_q   <= rx_err_n;
            buf_full   <= buf_full_n;
            buf_dat    <= buf_dat_n;
        end
    end

    // Next-state and next-output decode; line enables are computed here and registered.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 16'd1;
        bitn_n     = bitn;
        ph_n       = ph;
        clk_oe_n   = clk_oe_q;
        dta_oe_n   = dta_oe_q;
        rx_sh_n    = rx_sh;
        rx_par_n   = rx_par;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        rx_err_n   = 1'b0;
        buf_full_n = buf_full;
        buf_dat_n  = buf_dat;
        if (bus.tx_valid && bus.tx_ready) begin
            buf_full_n = 1'b1;
            buf_dat_n  = bus.tx_data;
        end
        case (state)
            S_IDLE: begin
                cnt_n    = '0;
                bitn_n   = '0;
                ph_n     = 1'b0;
                clk_oe_n = 1'b0;
                dta_oe_n = 1'b0;
                // Host request-to-send wins over a pending byte.
                if (rts_cnt == HALF_C) begin
                    state_n  = S_RX;
                    bitn_n   = 4'd1;
                    clk_oe_n = 1'b1;
                end else if (buf_full && idle_cnt >= IDLE_C) begin
                    state_n  = S_TX;
                    dta_oe_n = ~tx_frame[0];
                end
            end
            S_TX: begin
                if (!ph) begin
                    // Host inhibit aborts the frame unless we are already on the stop bit.
                    if (cnt >= CHK_C && !clk_s && bitn != 4'd10) begin
                        state_n  = S_HOLD;
                        cnt_n    = '0;
                        clk_oe_n = 1'b0;
                        dta_oe_n = 1'b0;
                    end else if (phase_end) begin
                        ph_n     = 1'b1;
                        cnt_n    = '0;
                        clk_oe_n = 1'b1;
                    end
                end else if (phase_end) begin
                    cnt_n = '0;
                    if (bitn == 4'd10) begin
                        state_n    = S_HOLD;
                        clk_oe_n   = 1'b0;
                        dta_oe_n   = 1'b0;
                        buf_full_n = 1'b0;
                    end else begin
                        bitn_n   = bitn + 4'd1;
                        ph_n     = 1'b0;
                        clk_oe_n = 1'b0;
                        dta_oe_n = ~tx_frame[bitn + 4'd1];
                    end
                end
            end
            S_RX: begin
                if (!ph) begin
                    if (phase_end) begin
                        ph_n     = 1'b1;
                        cnt_n    = '0;
                        clk_oe_n = 1'b0;
                    end
                end else if (cnt >= CHK_C && !clk_s) begin
                    state_n  = S_HOLD;
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                    dta_oe_n = 1'b0;
                    rx_err_n = 1'b1;
                end else if (cnt == MID_C && bitn == 4'd10 && !dta_s) begin
                    // Framing error: no acknowledge pulse.
                    state_n  = S_HOLD;
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                    dta_oe_n = 1'b0;
                    rx_err_n = 1'b1;
                end else if (phase_end) begin
                    cnt_n = '0;
                    if (bitn == 4'd11) begin
                        state_n  = S_HOLD;
                        clk_oe_n = 1'b0;
                        dta_oe_n = 1'b0;
                        if (^{rx_sh, rx_par}) begin
                            rx_data_n  = rx_sh;
                            rx_valid_n = 1'b1;
                        end else begin
                            rx_err_n = 1'b1;
                        end
                    end else begin
                        bitn_n   = bitn + 4'd1;
                        ph_n     = 1'b0;
                        clk_oe_n = 1'b1;
                        dta_oe_n = (bitn == 4'd10);
                    end
                end else if (cnt == MID_C) begin
                    if (bitn <= 4'd8) rx_sh_n = {dta_s, rx_sh[7:1]};
                    else if (bitn == 4'd9) rx_par_n = dta_s;
                end
            end
            S_HOLD: begin
                cnt_n    = '0;
                clk_oe_n = 1'b0;
                dta_oe_n = 1'b0;
                if (idle_cnt >= IDLE_C) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_device_port.sv
// Directed bench for ps2_device_port with a wired-AND pad model and a scripted PS/2 host.
// Runs at 4 MHz so HALF=160 and IDLE=200 cycles keep the frames short.
// Host pulls lines low through host_clk_low/host_dta_low; outputs sampled on negedge.
module tb_ps2_device_port;
    localparam int HALF = 160;
    localparam int IDLE = 200;
    localparam int WB   = 2 * IDLE + 4 * HALF;

    logic clk = 1'b0;
    logic reset;
    logic ps2clk_in, ps2dta_in, ps2clk_oe, ps2dta_oe;
    logic host_clk_low = 1'b0;
    logic host_dta_low = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ps2_device_port_if bus();

    ps2_device_port #(.CLKFREQ(4_000_000), .HALF_US(40), .IDLE_US(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2clk_in (ps2clk_in),
        .ps2dta_in (ps2dta_in),
        .ps2clk_oe (ps2clk_oe),
        .ps2dta_oe (ps2dta_oe),
        .bus       (bus.slave)
    );

    assign ps2clk_in = ~(ps2clk_oe | host_clk_low);
    assign ps2dta_in = ~(ps2dta_oe | host_dta_low);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_clk_oe(input logic lvl, input int budget, output int to);
        to = 1;
        for (int c = 0; c < budget; c++) begin
            if (ps2clk_oe == lvl) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int to;
        to = 1;
        for (int c = 0; c < WB; c++) begin
            if (!bus.busy) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
        chk(tag, to, 0);
    endtask

    // Watches device clock falling edges on the line until tx_ready returns.
    task automatic capture_tx(input int budget, output int edges, output logic [10:0] bits,
                              output int spacing_bad, output int timed_out);
        logic prev;
        int   last_t;
        edges = 0; bits = '0; spacing_bad = 0; timed_out = 1; prev = 1'b0; last_t = 0;
        for (int c = 0; c < budget; c++) begin
            if (ps2clk_oe && !prev) begin
                bits = {ps2dta_in, bits[10:1]};
                if (edges > 0 && (c - last_t) != 2 * HALF) spacing_bad++;
                last_t = c;
                edges++;
            end
            prev = ps2clk_oe;
            if (bus.tx_ready) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Host-to-device byte: RTS, then drive bit k after device falling edge k+1.
    task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                             output int pulses, output int ack_len, output int nv,
                             output int ne, output int timed_out);
        logic       prev;
        logic [9:0] fr;
        int         extra;
        fr = {stop, par, d};
        pulses = 0; ack_len = 0; nv = 0; ne = 0; timed_out = 1; prev = 1'b0; extra = -1;
        host_dta_low = 1'b1;
        for (int c = 0; c < 28 * HALF; c++) begin
            if (ps2clk_oe && !prev) begin
                pulses++;
                if (pulses <= 10) begin
                    host_dta_low = ~fr[0];
                    fr = {1'b1, fr[9:1]};
                end else begin
                    host_dta_low = 1'b0;
                end
            end
            prev = ps2clk_oe;
            if (ps2dta_oe) ack_len++;
            if (bus.rx_valid) nv++;
            if (bus.rx_err) ne++;
            if (extra < 0 && (bus.rx_valid || bus.rx_err)) begin
                extra = 5;
                host_dta_low = 1'b0;
            end else if (extra > 0) begin
                extra--;
            end
            if (extra == 0) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        host_dta_low = 1'b0;
    endtask

    initial begin
        int          edges, sbad, to, tos, pulses, ack, nv, ne, cyc, oe_after;
        logic [10:0] bits;

        reset = 1'b1;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        step(3);
        chk("rst_clk_oe", ps2clk_oe, 0);
        chk("rst_dta_oe", ps2dta_oe, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_err", bus.rx_err, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        step(1);
        chk("post_rst_tx_ready", bus.tx_ready, 1);

        // 1: plain transmit of 0x1C
        bus.tx_data = 8'h1C; bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        chk("t1_tx_ready_low", bus.tx_ready, 0);
        chk("t1_busy", bus.busy, 1);
        capture_tx(IDLE + 14 * 2 * HALF, edges, bits, sbad, to);
        chk("t1_timeout", to, 0);
        chk("t1_edges", edges, 11);
        chk("t1_bits", bits, 11'b1_0_00011100_0);
        chk("t1_spacing", sbad, 0);
        chk("t1_clk_oe_end", ps2clk_oe, 0);
        chk("t1_dta_oe_end", ps2dta_oe, 0);
        wait_idle("t1_idle_timeout");

        // 2: host inhibit at bit 4, then retransmission
        bus.tx_data = 8'h1C; bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        tos = 0;
        for (int k = 0; k < 4; k++) begin
            wait_clk_oe(1'b1, WB, to); tos += to;
            wait_clk_oe(1'b0, WB, to); tos += to;
        end
        chk("t2_reach_bit4", tos, 0);
        host_clk_low = 1'b1;
        oe_after = 0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (c >= 65 && (ps2clk_oe || ps2dta_oe)) oe_after++;
        end
        chk("t2_released", oe_after, 0);
        chk("t2_tx_ready_held", bus.tx_ready, 0);
        chk("t2_busy_held", bus.busy, 1);
        host_clk_low = 1'b0;
        cyc = -1;
        for (int c = 0; c < WB; c++) begin
            if (ps2dta_oe) begin
                cyc = c;
                break;
            end
            step(1);
        end
        chk("t2_restart_gap_ok", (cyc >= IDLE && cyc <= IDLE + 10), 1);
        capture_tx(14 * 2 * HALF, edges, bits, sbad, to);
        chk("t2_timeout", to, 0);
        chk("t2_edges", edges, 11);
        chk("t2_bits", bits, 11'b1_0_00011100_0);
        chk("t2_spacing", sbad, 0);
        wait_idle("t2_idle_timeout");

        // 3: host sends 0xFF with correct parity
        host_send(8'hFF, 1'b1, 1'b1, pulses, ack, nv, ne, to);
        chk("t3_timeout", to, 0);
        chk("t3_pulses", pulses, 11);
        chk("t3_ack_len", ack, 2 * HALF);
        chk("t3_rx_valid_cycles", nv, 1);
        chk("t3_rx_err_cycles", ne, 0);
        chk("t3_rx_data", bus.rx_data, 8'hFF);
        wait_idle("t3_idle_timeout");

        // 4a: 0xED with wrong parity
        host_send(8'hED, 1'b0, 1'b1, pulses, ack, nv, ne, to);
        chk("t4a_timeout", to, 0);
        chk("t4a_pulses", pulses, 11);
        chk("t4a_ack_len", ack, 2 * HALF);
        chk("t4a_rx_valid_cycles", nv, 0);
        chk("t4a_rx_err_cycles", ne, 1);
        chk("t4a_rx_data", bus.rx_data, 8'hFF);
        wait_idle("t4a_idle_timeout");

        // 4b: 0xED with good parity but stop bit 0
        host_send(8'hED, 1'b1, 1'b0, pulses, ack, nv, ne, to);
        chk("t4b_timeout", to, 0);
        chk("t4b_pulses", pulses, 10);
        chk("t4b_ack_len", ack, 0);
        chk("t4b_rx_valid_cycles", nv, 0);
        chk("t4b_rx_err_cycles", ne, 1);
        chk("t4b_rx_data", bus.rx_data, 8'hFF);
        wait_idle("t4b_idle_timeout");

        // 5: tx byte offered as host RTS settles; RX goes first
        host_dta_low = 1'b1;
        step(HALF + 2);
        bus.tx_data = 8'hAA; bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        chk("t5_tx_ready_low", bus.tx_ready, 0);
        host_send(8'hED, 1'b1, 1'b1, pulses, ack, nv, ne, to);
        chk("t5_rx_timeout", to, 0);
        chk("t5_pulses", pulses, 11);
        chk("t5_rx_valid_cycles", nv, 1);
        chk("t5_rx_data", bus.rx_data, 8'hED);
        cyc = -1;
        for (int c = 0; c < WB; c++) begin
            if (ps2dta_oe) begin
                cyc = c;
                break;
            end
            step(1);
        end
        chk("t5_tx_gap_ok", (cyc >= IDLE - 10 && cyc <= IDLE + 10), 1);
        capture_tx(14 * 2 * HALF, edges, bits, sbad, to);
        chk("t5_timeout", to, 0);
        chk("t5_edges", edges, 11);
        chk("t5_bits", bits, 11'b1_1_10101010_0);
        chk("t5_spacing", sbad, 0);
        wait_idle("t5_idle_timeout");

        // 6: reset during bit 6 (low phase) of a 0x55 frame
        bus.tx_data = 8'h55; bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        tos = 0;
        for (int k = 0; k < 6; k++) begin
            wait_clk_oe(1'b1, WB, to); tos += to;
            wait_clk_oe(1'b0, WB, to); tos += to;
        end
        wait_clk_oe(1'b1, WB, to); tos += to;
        chk("t6_reach_bit6", tos, 0);
        step(30);
        chk("t6_pre_clk_oe", ps2clk_oe, 1);
        chk("t6_pre_dta_oe", ps2dta_oe, 1);
        reset = 1'b1;
        step(1);
        chk("t6_clk_oe", ps2clk_oe, 0);
        chk("t6_dta_oe", ps2dta_oe, 0);
        chk("t6_tx_ready", bus.tx_ready, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_rx_data", bus.rx_data, 0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("t6_post_tx_ready", bus.tx_ready, 1);
        oe_after = 0;
        for (int c = 0; c < 3 * IDLE + 2 * HALF; c++) begin
            step(1);
            if (ps2clk_oe || ps2dta_oe || bus.busy) oe_after++;
        end
        chk("t6_no_residual", oe_after, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_device_port.md
Name: ps2_device_port

Overview:
- Device-side end of the PS/2 link; emulates a keyboard or mouse toward a PS/2 host.
- Generates the PS/2 clock and transmits bytes (scan codes, command responses) to the host.
- Detects a host request-to-send, clocks in the host command byte and acknowledges it.
- Lines are open-drain. The block only drives low, via output enables; the top level builds the inout pads.

Parameters:
CLKFREQ, 12_000_000, system clock frequency in Hz
HALF_US, 40, PS/2 clock half period in µs; HALF = CLKFREQ/1_000_000*HALF_US cycles (480)
IDLE_US, 50, both lines high this long before a transmission may start; IDLE cycles (600)

Ports:
clk  in  1  system clock, 12 MHz
reset  in  1  synchronous, active-high reset
ps2clk_in  in  1  PS/2 clock pad value (asynchronous)
ps2dta_in  in  1  PS/2 data pad value (asynchronous)
ps2clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
ps2dta_oe  out  1  1 = pull PS/2 data low, 0 = release
tx_data  in  8  byte to send to host
tx_valid  in  1  tx_data offered
tx_ready  out  1  byte accepted when tx_valid&tx_ready
rx_data  out  8  last host byte, held until next reception
rx_valid  out  1  one-cycle pulse, rx_data good
rx_err  out  1  one-cycle pulse, parity or framing error
busy  out  1  state != IDLE or a byte is buffered

Behaviour:
- Reset values: ps2clk_oe=0, ps2dta_oe=0, tx_ready=0, rx_data=0, rx_valid=0, rx_err=0, busy=0, buffer empty. tx_ready=1 from the first cycle after reset deasserts.
- Reset mid-frame: both oe drop on the next clock edge; the buffered byte is discarded.
- Pad inputs pass through 2-flop synchronizers. All decisions use the synchronized values (2-cycle latency).
- Buffer: one byte. tx_ready = buffer empty. The byte stays buffered until it is sent completely.
- Idle counter: counts while synced clk=1 and dta=1; clears otherwise.
- IDLE state, priority order:
  - (1) Synced clk=1 and dta=0 stable for HALF cycles: host RTS, go RX.
  - (2) Buffer full and idle counter >= IDLE: go TX.
  - Simultaneous RTS and pending byte: RX first, TX afterwards.
- TX frame: 11 bits, LSB first: start 0, D0..D7, odd parity (bit = ~^data), stop 1.
  - Each bit has a HIGH phase then a LOW phase.
  - HIGH phase: ps2clk_oe=0 for HALF cycles. ps2dta_oe = ~bit is set on the first cycle of the phase.
  - LOW phase: ps2clk_oe=1 for HALF cycles.
  - Falling-edge spacing is 2*HALF.
- TX abort (host inhibit):
  - Checked from 5 µs into each HIGH phase. If synced clk=0 during bits 0..9, release both lines and go HOLDOFF.
  - The byte stays buffered and is retransmitted from the start bit once the lines are idle.
  - Inhibit during the stop bit (bit 10) is ignored; the byte counts as sent.
- TX complete: after the stop bit's LOW phase, release the clock, empty the buffer and go HOLDOFF.
- RX: the device produces 11 clock pulses, each a LOW phase then a HIGH phase of HALF cycles.
  - Data is sampled at the midpoint of each HIGH phase.
  - Pulses 1..8 give D0..D7. Pulse 9 gives parity. Pulse 10 gives stop.
  - Pulse 10 stop=1: the device drives ps2dta_oe=1 for the whole of pulse 11 (ack), then releases.
    - Parity ok: rx_data updates and rx_valid pulses in the cycle after ack release.
    - Parity bad: ack is still given, rx_err pulses, rx_data is unchanged.
  - Pulse 10 stop=0 (framing error): no ack, no pulse 11, rx_err pulses, go HOLDOFF.
  - Host pulling the clock low during a HIGH phase in RX: abort, rx_err pulse, go HOLDOFF.
- HOLDOFF: both oe=0, wait for idle counter >= IDLE, then go IDLE.
- rx_valid and rx_err never assert together. tx_valid is accepted in any state while the buffer is empty.

Test Plan:
1. tx_data=0x1C accepted, lines idle:
   - Exactly 11 falling clock edges, 960 cycles apart.
   - Data sampled at the edges = 0,0,0,1,1,1,0,0,0, parity 0, stop 1.
   - tx_ready returns to 1 after the last edge; oe both 0.
2. Send 0x1C, host holds the clock low for 100 µs starting at bit 4:
   - Both oe released within 65 cycles of inhibit.
   - Full 11-bit frame of 0x1C starts at least 600 cycles after the lines go high.
   - No tx_ready before completion.
3. Host RTS then sends 0xFF (parity 1, stop 1):
   - 11 device clock pulses; ps2dta_oe=1 during pulse 11.
   - rx_valid one cycle, rx_data=0xFF, rx_err=0.
4. Host sends 0xED with parity 0 (wrong), stop 1:
   - Ack given; rx_err one cycle; rx_valid=0; rx_data unchanged.
   - Repeat with correct parity but stop=0: no ack, rx_err pulse.
5. tx_valid with 0xAA in the same cycle the host RTS settles:
   - 0xED received first (rx_valid), then 0xAA transmitted correctly after 600 idle cycles.
6. reset asserted at bit 6 of a TX frame:
   - ps2clk_oe=ps2dta_oe=0 on the next edge; outputs at reset values.
   - No residual frame after reset release.
